sc_inst_encoder: RTL and testbench
==================================

Name: sc_inst_encoder

Overview:
- Inverse of the single-cycle CPU's control-unit decode: takes symbolic instruction requests (mnemonic index plus register, shamt, immediate and target fields) and assembles 32-bit MIPS-subset instruction words.
- Writes the words sequentially into instruction memory over a valid/ready write port.
- Used by the test harness and boot loader to build programs in IMEM without a software assembler.
- Encoding covers exactly the instruction set the control unit decodes, including the custom hamdis R-type.

Parameters:
ADDR_W, 8, width of the IMEM word address
DEPTH, 256, max words per program; must be <= 2**ADDR_W

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin new program at word address 0
in_valid  in  1  request valid
in_ready  out  1  encoder accepts request this cycle
in_last  in  1  request is final instruction of program
mnem  in  5  mnemonic index (see Behaviour)
rs, rt, rd  in  5 each  register fields
shamt  in  5  shift amount
imm  in  16  immediate / branch offset
target  in  26  jump target
wr_valid  out  1  IMEM write request
wr_ready  in  1  IMEM accepts write
wr_addr  out  ADDR_W  word address
wr_data  out  32  encoded instruction
count  out  ADDR_W+1  words written since start
busy  out  1  state is RUN or FULL
full  out  1  DEPTH requests accepted
done  out  1  one-cycle pulse when last write completes
err  out  1  sticky: invalid mnemonic seen since start

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0: in_ready, wr_valid, wr_addr, wr_data, count, busy, full, done, err. Internal issue counter is cleared.
- States:
  - IDLE -start-> RUN.
  - RUN -(DEPTH-th request accepted)-> FULL.
  - RUN/FULL -(write of last word completes)-> IDLE, with done pulsed in that cycle.
  - FULL stays in FULL until its pending write completes. If that word carried in_last, go to IDLE with done; otherwise stay in FULL, where only start exits.
- start in any state:
  - Goes to RUN and clears count, the issue counter and err.
  - Drops any pending wr_valid.
  - start has priority: no request is accepted in the start cycle.
- in_ready = (state==RUN) & ~start & (~wr_valid | wr_ready) & ~last_pending. last_pending is set by accepting an in_last request and cleared on done or start.
- Accept on in_valid & in_ready:
  - Valid mnemonic: register the encoded word into wr_data. wr_addr takes the issue counter, which then increments. wr_valid goes high the next cycle, so latency is 1.
  - Invalid mnemonic (21-31): err is set. Nothing is written and the issue counter is unchanged. If in_last is also set, done pulses the next cycle and state goes to IDLE.
- Write completes on wr_valid & wr_ready:
  - count increments.
  - wr_valid drops unless a new request is accepted in the same cycle. Back-to-back acceptance gives one word per cycle.
- wr_valid, wr_addr and wr_data are held stable while wr_ready=0.
- full = (issue counter == DEPTH). Requests presented while FULL are not accepted (in_ready=0).
- Encodings (op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] func[5:0]):
  - R-type (op=0): 0 add 100000, 1 sub 100010, 2 and 100100, 3 or 100101, 4 xor 100110, 9 hamdis 100111. Fields rs, rt, rd; shamt=0.
  - Shifts: 5 sll 000000, 6 srl 000010, 7 sra 000011. rs=0; fields rt, rd, shamt.
  - 8 jr 001000: rs only; rt, rd and shamt are 0.
  - I-type ({op, rs, rt, imm}): 10 addi 001000, 11 andi 001100, 12 ori 001101, 13 xori 001110, 14 lw 100011, 15 sw 101011, 16 beq 000100, 17 bne 000101.
  - 18 lui 001111: rs forced to 0.
  - J-type ({op, target}): 19 j 000010, 20 jal 000011.
- Unused field inputs never leak into the encoded word; they are masked to 0.
- An in_last write at address DEPTH-1 gives both full and done. The done pulse returns the state to IDLE and clears full.

Test Plan:
- Reset, start, then add (rs1 rt2 rd3) -> wr_valid next cycle, wr_addr=0, wr_data=0x00221820. With wr_ready=1: count=1.
- Back-to-back with wr_ready=1:
  - addi (rs0 rt1 imm5) -> 0x20010005 @0
  - lw (rs1 rt2 imm4) -> 0x8C220004 @1
  - sll (rt2 rd4 shamt3, rs input 7) -> 0x000220C0 @2
  - hamdis (rs2 rt3 rd1) -> 0x00430827 @3
  - in_ready stays 1 throughout.
- Stall: hold wr_ready=0 for 3 cycles while j (target 0x10) is pending -> wr_data=0x08000010 held stable, in_ready=0. Release -> count increments once.
- Invalid mnem=25 between two valid ops -> err=1, addresses stay contiguous (0,1), count=2. Then jal with in_last (target 0x40) -> 0x0C000040 @2, done pulse, busy=0.
- DEPTH=4 build, 5 requests with no in_last -> full=1 after the 4th accept, 5th never accepted.
- resetn=0 mid-stall -> all outputs 0 immediately, without waiting for a clock edge.
- start during a pending write -> pending write dropped, next accepted op goes to address 0.

Source files
------------

// File: rtl/sc_inst_encoder_if.sv
// Request/write/status bundle between a program source (master) and sc_inst_encoder (slave).
// The master issues symbolic instruction requests and acts as the IMEM write sink.
interface sc_inst_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              full;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_last, mnem, rs, rt, rd, shamt, imm, target, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data, count, busy, full, done, err
  );

  modport slave (
    input  start, in_valid, in_last, mnem, rs, rt, rd, shamt, imm, target, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data, count, busy, full, done, err
  );
endinterface

// File: rtl/sc_inst_encoder.sv
// Assembles symbolic MIPS-subset requests into 32-bit words and streams them into IMEM
// from address 0, one word per cycle when the write port keeps up.
module sc_inst_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic              clock,
  input logic              resetn,
  sc_inst_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t            state_q;
  logic [CNT_W-1:0]  issue_q;
  logic [CNT_W-1:0]  count_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              wr_last_q;
  logic              last_pend_q;
  logic              err_q;
  logic              done_q;
  logic [31:0]       enc_d;
  logic              mnem_ok;
  logic              accept;
  logic              wr_fire;

  // Each format masks the fields it does not own to zero.
  function automatic logic [31:0] encode(input logic [4:0] m, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [15:0] imm,
                                         input logic [25:0] tgt);
    logic [31:0] w;
    w = '0;
    case (m)
      5'd0:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      5'd1:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
      5'd2:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
      5'd3:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
      5'd4:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100110};
      5'd5:    w = {6'b000000, 5'd0, rt, rd, sh, 6'b000000};
      5'd6:    w = {6'b000000, 5'd0, rt, rd, sh, 6'b000010};
      5'd7:    w = {6'b000000, 5'd0, rt, rd, sh, 6'b000011};
      5'd8:    w = {6'b000000, rs, 15'd0, 6'b001000};
      5'd9:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100111};
      5'd10:   w = {6'b001000, rs, rt, imm};
      5'd11:   w = {6'b001100, rs, rt, imm};
      5'd12:   w = {6'b001101, rs, rt, imm};
      5'd13:   w = {6'b001110, rs, rt, imm};
      5'd14:   w = {6'b100011, rs, rt, imm};
      5'd15:   w = {6'b101011, rs, rt, imm};
      5'd16:   w = {6'b000100, rs, rt, imm};
      5'd17:   w = {6'b000101, rs, rt, imm};
      5'd18:   w = {6'b001111, 5'd0, rt, imm};
      5'd19:   w = {6'b000010, tgt};
      5'd20:   w = {6'b000011, tgt};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign enc_d   = encode(bus.mnem, bus.rs, bus.rt, bus.rd, bus.shamt, bus.imm, bus.target);
  assign mnem_ok = (bus.mnem <= 5'd20);
  assign wr_fire = wr_valid_q & bus.wr_ready;
  assign bus.in_ready = (state_q == RUN) & ~bus.start & (~wr_valid_q | bus.wr_ready) & ~last_pend_q;
  assign accept  = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      count_q     <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_last_q   <= 1'b0;
      last_pend_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        state_q     <= RUN;
        issue_q     <= '0;
        count_q     <= '0;
        wr_valid_q  <= 1'b0;
        wr_last_q   <= 1'b0;
        last_pend_q <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        if (wr_fire) begin
          count_q    <= count_q + ONE;
          wr_valid_q <= 1'b0;
        end
        if (accept && mnem_ok) begin
          wr_valid_q <= 1'b1;
          wr_data_q  <= enc_d;
          wr_addr_q  <= issue_q[ADDR_W-1:0];
          wr_last_q  <= bus.in_last;
          issue_q    <= issue_q + ONE;
          if (bus.in_last) last_pend_q <= 1'b1;
          if (issue_q == LAST_IDX) state_q <= FULL;
        end else if (accept) begin
          err_q <= 1'b1;
          if (bus.in_last) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        // Clearing the issue counter on completion is what drops full after a DEPTH-word program.
        if (wr_fire && wr_last_q) begin
          done_q      <= 1'b1;
          state_q     <= IDLE;
          last_pend_q <= 1'b0;
          issue_q     <= '0;
        end
      end
    end
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.full     = (issue_q == DEPTH_C);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_sc_inst_encoder.sv
// Bench for sc_inst_encoder: directed program scenarios plus random traffic against a
// transaction-level model (format table encoder, write queue, counters).
module tb_sc_inst_encoder;
  localparam int AW = 8, DEPTH = 256, AW4 = 2, DEPTH4 = 4;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  sc_inst_encoder_if #(.ADDR_W(AW))  bus ();
  sc_inst_encoder_if #(.ADDR_W(AW4)) bus4 ();

  sc_inst_encoder #(.ADDR_W(AW), .DEPTH(DEPTH)) u_dut (
    .clock(clock), .resetn(resetn), .bus(bus));
  sc_inst_encoder #(.ADDR_W(AW4), .DEPTH(DEPTH4)) u_dut4 (
    .clock(clock), .resetn(resetn), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: field placement by arithmetic from per-mnemonic opcode/func tables.
  function automatic logic [31:0] ref_enc(input longint m, input longint rs, input longint rt,
                                          input longint rd, input longint sh, input longint imm,
                                          input longint tgt);
    longint fn[10];
    longint op[8];
    longint w;
    fn = '{32, 34, 36, 37, 38, 0, 2, 3, 8, 39};
    op = '{8, 12, 13, 14, 35, 43, 4, 5};
    if (m <= 4 || m == 9)  w = rs * 2**21 + rt * 2**16 + rd * 2**11 + fn[m];
    else if (m <= 7)       w = rt * 2**16 + rd * 2**11 + sh * 64 + fn[m];
    else if (m == 8)       w = rs * 2**21 + 8;
    else if (m <= 17)      w = op[m-10] * 2**26 + rs * 2**21 + rt * 2**16 + imm;
    else if (m == 18)      w = 15 * 2**26 + rt * 2**16 + imm;
    else if (m <= 20)      w = (m - 17) * 2**26 + tgt;
    else                   w = 0;
    return w[31:0];
  endfunction

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          last;
  } item_t;

  item_t q[$];
  int    m_issue, m_count;
  bit    m_err, m_busy, m_lastpend;
  bit    s_rdy;

  task automatic model_reset();
    q.delete();
    m_issue = 0; m_count = 0; m_err = 0; m_busy = 0; m_lastpend = 0;
  endtask

  // Called just after a rising edge with inputs already driven; advances one cycle.
  task automatic step();
    bit    exp_rdy, acc, fire, done_exp;
    item_t it;
    #1;
    exp_rdy = m_busy && (m_issue != DEPTH) && !bus.start && (q.size() == 0 || bus.wr_ready) && !m_lastpend;
    check("in_ready", bus.in_ready, exp_rdy);
    s_rdy    = bus.in_ready;
    acc      = bus.in_valid && exp_rdy;
    fire     = (q.size() != 0) && bus.wr_ready;
    done_exp = 0;
    if (fire) begin
      it = q.pop_front();
      check("wr_addr", bus.wr_addr, it.addr);
      check("wr_data", bus.wr_data, it.data);
      m_count++;
      if (it.last) begin done_exp = 1; m_busy = 0; m_lastpend = 0; m_issue = 0; end
    end
    if (acc) begin
      if (bus.mnem <= 20) begin
        it.addr = m_issue;
        it.data = ref_enc(bus.mnem, bus.rs, bus.rt, bus.rd, bus.shamt, bus.imm, bus.target);
        it.last = bus.in_last;
        q.push_back(it);
        m_issue++;
        if (bus.in_last) m_lastpend = 1;
      end else begin
        m_err = 1;
        if (bus.in_last) begin done_exp = 1; m_busy = 0; end
      end
    end
    if (bus.start) begin
      q.delete();
      m_count = 0; m_issue = 0; m_err = 0; m_busy = 1; m_lastpend = 0; done_exp = 0;
    end
    @(posedge clock); #1;
    check("count", bus.count, m_count);
    check("err", bus.err, m_err);
    check("done", bus.done, done_exp);
    check("busy", bus.busy, m_busy);
    check("wr_valid", bus.wr_valid, q.size() != 0);
    check("full", bus.full, m_busy && m_issue == DEPTH);
  endtask

  task automatic req(input int m, input int rs, input int rt, input int rd, input int sh,
                     input int imm, input int tgt, input bit last);
    bus.in_valid = 1'b1;
    bus.mnem     = 5'(m);
    bus.rs       = 5'(rs);
    bus.rt       = 5'(rt);
    bus.rd       = 5'(rd);
    bus.shamt    = 5'(sh);
    bus.imm      = 16'(imm);
    bus.target   = 26'(tgt);
    bus.in_last  = last;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    idle_in();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, bus.in_ready, 0);
    check({pfx, "_wr_valid"}, bus.wr_valid, 0);
    check({pfx, "_wr_addr"},  bus.wr_addr, 0);
    check({pfx, "_wr_data"},  bus.wr_data, 0);
    check({pfx, "_count"},    bus.count, 0);
    check({pfx, "_busy"},     bus.busy, 0);
    check({pfx, "_full"},     bus.full, 0);
    check({pfx, "_done"},     bus.done, 0);
    check({pfx, "_err"},      bus.err, 0);
    check({pfx, "_d4_busy"},  bus4.busy, 0);
    check({pfx, "_d4_count"}, bus4.count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, acc4;
    bus.start = 0; bus.wr_ready = 0; req(0, 0, 0, 0, 0, 0, 0, 0); idle_in();
    bus4.start = 0; bus4.in_valid = 0; bus4.in_last = 0; bus4.wr_ready = 0;
    bus4.mnem = 0; bus4.rs = 0; bus4.rt = 0; bus4.rd = 0; bus4.shamt = 0;
    bus4.imm = 0; bus4.target = 0;
    model_reset();

    #3 resetn = 1'b0;
    #1 check_reset_outputs("rst");
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;

    // First word: add, latency 1.
    bus.wr_ready = 1'b1;
    pulse_start();
    req(0, 1, 2, 3, 0, 0, 0, 0);
    step();
    check("add_wr_valid", bus.wr_valid, 1);
    check("add_addr", bus.wr_addr, 0);
    check("add_data", bus.wr_data, 32'h00221820);
    idle_in();
    step();
    check("add_count", bus.count, 1);

    // Back-to-back stream.
    pulse_start();
    req(10, 0, 1, 0, 0, 5, 0, 0); step();
    check("addi_rdy", s_rdy, 1); check("addi_data", bus.wr_data, 32'h20010005); check("addi_addr", bus.wr_addr, 0);
    req(14, 1, 2, 0, 0, 4, 0, 0); step();
    check("lw_rdy", s_rdy, 1); check("lw_data", bus.wr_data, 32'h8C220004); check("lw_addr", bus.wr_addr, 1);
    req(5, 7, 2, 4, 3, 0, 0, 0); step();
    check("sll_rdy", s_rdy, 1); check("sll_data", bus.wr_data, 32'h000220C0); check("sll_addr", bus.wr_addr, 2);
    req(9, 2, 3, 1, 0, 0, 0, 0); step();
    check("hamdis_rdy", s_rdy, 1); check("hamdis_data", bus.wr_data, 32'h00430827); check("hamdis_addr", bus.wr_addr, 3);
    idle_in(); step();

    // Stall on j.
    bus.wr_ready = 1'b0;
    req(19, 0, 0, 0, 0, 0, 'h10, 0); step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", bus.wr_data, 32'h08000010);
      check("stall_rdy", s_rdy, 0);
    end
    cnt0 = int'(bus.count);
    bus.wr_ready = 1'b1;
    step(); check("stall_release_count", bus.count, cnt0 + 1);
    step(); check("stall_once_count", bus.count, cnt0 + 1);

    // Invalid mnemonic between valid ops, then jal as last.
    pulse_start();
    req(0, 1, 2, 3, 0, 0, 0, 0); step();
    req(25, 9, 9, 9, 9, 'hFFFF, 'h3FFFFFF, 0); step();
    req(1, 4, 5, 6, 0, 0, 0, 0); step();
    check("inv_contig_addr", bus.wr_addr, 1);
    idle_in(); step();
    check("inv_err", bus.err, 1);
    check("inv_count", bus.count, 2);
    req(20, 0, 0, 0, 0, 0, 'h40, 1); step();
    check("jal_addr", bus.wr_addr, 2);
    check("jal_data", bus.wr_data, 32'h0C000040);
    idle_in(); step();
    check("jal_done", bus.done, 1);
    check("jal_busy", bus.busy, 0);
    step();
    check("jal_done_pulse", bus.done, 0);

    // start while a write is pending.
    bus.wr_ready = 1'b0;
    pulse_start();
    req(0, 1, 1, 1, 0, 0, 0, 0); step();
    idle_in();
    pulse_start();
    check("restart_drop", bus.wr_valid, 0);
    bus.wr_ready = 1'b1;
    req(3, 7, 8, 9, 0, 0, 0, 0); step();
    check("restart_addr", bus.wr_addr, 0);
    idle_in(); step();

    // DEPTH=4 instance: five requests offered, only four fit.
    bus4.start = 1'b1; @(posedge clock); #1;
    bus4.start = 1'b0; bus4.wr_ready = 1'b1;
    acc4 = 0;
    for (int i = 0; i < 10; i++) begin
      bus4.in_valid = (acc4 < 5);
      bus4.mnem = 5'($urandom_range(0, 20));
      bus4.rs = 5'($urandom); bus4.rt = 5'($urandom); bus4.rd = 5'($urandom);
      #1;
      if (bus4.in_valid && bus4.in_ready) begin
        acc4++;
        @(posedge clock); #1;
        if (acc4 == 4) check("d4_full_after_4th", bus4.full, 1);
      end else begin
        @(posedge clock); #1;
      end
    end
    bus4.in_valid = 1'b0;
    check("d4_accepts", acc4, 4);
    check("d4_full", bus4.full, 1);
    check("d4_busy", bus4.busy, 1);
    check("d4_count", bus4.count, 4);
    #1 check("d4_rdy", bus4.in_ready, 0);

    // Randomised traffic.
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      bus.start    = !m_busy;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.mnem     = 5'($urandom_range(0, 23));
      bus.rs       = 5'($urandom); bus.rt = 5'($urandom); bus.rd = 5'($urandom);
      bus.shamt    = 5'($urandom); bus.imm = 16'($urandom); bus.target = 26'($urandom);
      bus.in_last  = ($urandom_range(0, 29) == 0);
      bus.wr_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.start = 1'b0;

    // Asynchronous reset in the middle of a stall.
    bus.wr_ready = 1'b0;
    pulse_start();
    req(4, 3, 4, 5, 0, 0, 0, 0); step();
    idle_in(); step();
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge clock); #1;
    resetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
